// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit feeding the HI/LO register pair.
// Multiplies take two cycles. Divides use a restoring divider that produces one
// quotient bit per cycle.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (op codes 4-7).
module mult_div_unit #(
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    output logic        busy,
    output logic        finish,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MUL1     = 3'd1;
    localparam logic [2:0] ST_MUL2     = 3'd2;
    localparam logic [2:0] ST_DIV_PREP = 3'd3;
    localparam logic [2:0] ST_DIV_ITER = 3'd4;
    localparam logic [2:0] ST_DIV_FIX  = 3'd5;

    localparam int unsigned CW = $clog2(DIV_ITER);
    localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITER - 1);

    logic [2:0]    state_q, state_d;
    logic [31:0]   a_q, b_q;
    logic          sgn_q;
    logic [63:0]   prod_q;
    logic [31:0]   quo_q, rem_q;
    logic          negq_q, negr_q;
    logic [CW-1:0] cnt_q;

    logic        op_ok, accept, done;
    logic        neg_a, neg_b;
    logic [63:0] ext_a, ext_b, mul_full, acc_res;
    logic [32:0] rem_sh, diff;

`ifdef MDU_MADD_EN
    logic        acc_q, sub_q;
    logic [31:0] hi_acc_q, lo_acc_q;
    assign op_ok = 1'b1;
`else
    logic unused_acc;
    assign unused_acc = ^{hi_in, lo_in};
    assign op_ok = !op_code[2];
`endif

    assign busy   = (state_q != ST_IDLE);
    assign accept = (state_q == ST_IDLE) && op_valid && !flush && op_ok;
    // A flush in the completing cycle suppresses the result.
    assign done   = !flush && ((state_q == ST_MUL2) || (state_q == ST_DIV_FIX));

    // Datapath helpers: operand extension, product, accumulate and one divide step.
    always_comb begin
        neg_a    = sgn_q && a_q[31];
        neg_b    = sgn_q && b_q[31];
        ext_a    = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b    = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        mul_full = ext_a * ext_b;
`ifdef MDU_MADD_EN
        if (!acc_q) begin
            acc_res = prod_q;
        end else if (sub_q) begin
            acc_res = {hi_acc_q, lo_acc_q} - prod_q;
        end else begin
            acc_res = {hi_acc_q, lo_acc_q} + prod_q;
        end
`else
        acc_res = prod_q;
`endif
        rem_sh = {rem_q, quo_q[31]};
        diff   = rem_sh - {1'b0, b_q};
    end

    // Next-state logic; flush forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (op_code[2:1] == 2'b01) ? ST_DIV_PREP : ST_MUL1;
                end
            end
            ST_MUL1:     state_d = ST_MUL2;
            ST_MUL2:     state_d = ST_IDLE;
            // A zero divisor skips the iteration loop; DIV_FIX loads the fixed result.
            ST_DIV_PREP: state_d = (b_q == 32'd0) ? ST_DIV_FIX : ST_DIV_ITER;
            ST_DIV_ITER: state_d = (cnt_q == LAST_ITER) ? ST_DIV_FIX : ST_DIV_ITER;
            ST_DIV_FIX:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // State, operand latches, datapath registers and registered results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            finish  <= 1'b0;
            hi_out  <= 32'd0;
            lo_out  <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            prod_q  <= 64'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef MDU_MADD_EN
            acc_q    <= 1'b0;
            sub_q    <= 1'b0;
            hi_acc_q <= 32'd0;
            lo_acc_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            finish  <= done;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q   <= src_a;
                        b_q   <= src_b;
                        sgn_q <= !op_code[0];
`ifdef MDU_MADD_EN
                        acc_q    <= op_code[2];
                        sub_q    <= op_code[1];
                        hi_acc_q <= hi_in;
                        lo_acc_q <= lo_in;
`endif
                    end
                end
                ST_MUL1: prod_q <= mul_full;
                ST_MUL2: begin
                    if (done) begin
                        {hi_out, lo_out} <= acc_res;
                    end
                end
                ST_DIV_PREP: begin
                    // Dividend magnitude seeds the quotient shift register.
                    quo_q  <= neg_a ? -a_q : a_q;
                    b_q    <= neg_b ? -b_q : b_q;
                    rem_q  <= 32'd0;
                    cnt_q  <= '0;
                    negq_q <= neg_a ^ neg_b;
                    negr_q <= neg_a;
                end
                ST_DIV_ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!diff[32]) begin
                        rem_q <= diff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                end
                ST_DIV_FIX: begin
                    if (done) begin
                        if (b_q == 32'd0) begin
                            hi_out <= a_q;
                            lo_out <= 32'hFFFF_FFFF;
                        end else begin
                            hi_out <= negr_q ? -rem_q : rem_q;
                            lo_out <= negq_q ? -quo_q : quo_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected {HI,LO} and finish
// cycle; the monitor pops and compares on every finish pulse.
// Build with MDU_MADD_EN defined to exercise the accumulate ops.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] src_a = 32'd0, src_b = 32'd0, hi_in = 32'd0, lo_in = 32'd0;
    logic        flush = 1'b0;
    logic        busy, finish;
    logic [31:0] hi_out, lo_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vecs = 0;
    int   miscompares = 0;
    int   fin_cnt = 0;
    int   last_acc = 0;

    mult_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_code  (op_code),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi_in    (hi_in),
        .lo_in    (lo_in),
        .flush    (flush),
        .busy     (busy),
        .finish   (finish),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every finish pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst && finish) begin
            fin_cnt++;
            vecs++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_finish: finish=1 at cycle %0d, none expected", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (hi_out !== e.hi || lo_out !== e.lo || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL result: got hi=%h lo=%h cycle=%0d, want hi=%h lo=%h cycle=%0d",
                             hi_out, lo_out, cyc, e.hi, e.lo, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called on a negedge. Holds op_valid until the unit is idle, then records acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hin, input logic [31:0] lin,
                         input logic [31:0] eh, input logic [31:0] el, input int lat,
                         input bit push);
        int guard;
        exp_t e;
        guard    = 0;
        op_valid = 1'b1;
        op_code  = op;
        src_a    = a;
        src_b    = b;
        hi_in    = hin;
        lo_in    = lin;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            vecs++;
            miscompares++;
            $display("FAIL accept_timeout: busy=%0b after %0d cycles, want 0", busy, guard);
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        op_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            vecs++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results still pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int f0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_finish", {31'd0, finish}, 32'd0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // MULT with busy profile over its two cycles.
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, 1);
        check("mult_busy_c1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("mult_busy_c2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("mult_busy_done", {31'd0, busy}, 32'd0);
        drain();

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'h0000_0001, 2, 1);
        drain();
        issue(3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2, 1);
        drain();
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1);
        drain();
        issue(3'd3, 32'd7, 32'd2, 0, 0, 32'd1, 32'd3, 34, 1);
        drain();
        issue(3'd2, 32'd5, 32'd0, 0, 0, 32'd5, 32'hFFFF_FFFF, 2, 1);
        drain();
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 32'h8000_0000, 34, 1);
        drain();
        issue(3'd2, 32'd100, 32'hFFFF_FFF9, 0, 0, 32'd2, 32'hFFFF_FFF2, 34, 1);
        drain();
        issue(3'd3, 32'hFFFF_FFFF, 32'd10, 0, 0, 32'd5, 32'h1999_9999, 34, 1);
        drain();

        // Back-to-back: second op waits while busy, then is taken on the finish cycle.
        issue(3'd1, 32'd2, 32'd3, 0, 0, 32'd0, 32'd6, 2, 1);
        issue(3'd0, 32'd7, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2, 1);
        drain();

        // Flush a DIVU mid-iteration.
        issue(3'd3, 32'd100, 32'd7, 0, 0, 0, 0, 0, 0);
        while (cyc < last_acc + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        f0 = fin_cnt;
        repeat (40) @(negedge clk);
        check("flush_no_finish", 32'(fin_cnt - f0), 32'd0);
        check("flush_hi_hold", hi_out, 32'hFFFF_FFFF);
        check("flush_lo_hold", lo_out, 32'hFFFF_FFF9);
        issue(3'd0, 32'd2, 32'd3, 0, 0, 32'd0, 32'd6, 2, 1);
        drain();

        // Reset mid-divide with a new request pending.
        issue(3'd2, 32'd1000, 32'd3, 0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        op_valid = 1'b1;
        op_code  = 3'd2;
        rst      = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_finish", {31'd0, finish}, 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        op_valid = 1'b0;
        rst      = 1'b1;
        f0 = fin_cnt;
        repeat (40) @(negedge clk);
        check("rst_no_finish", 32'(fin_cnt - f0), 32'd0);

`ifdef MDU_MADD_EN
        issue(3'd6, 32'd2, 32'd3, 32'd0, 32'd10, 32'd0, 32'd4, 2, 1);
        drain();
        issue(3'd4, 32'd2, 32'd3, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'd5, 2, 1);
        drain();
        issue(3'd7, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1);
        drain();
        issue(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFE, 32'd2, 2, 1);
        drain();
        issue(3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 2, 1);
        drain();
`else
        // Accumulate ops are rejected: no busy, no finish.
        f0 = fin_cnt;
        for (int op = 4; op < 8; op++) begin
            op_valid = 1'b1;
            op_code  = 3'(op);
            src_a    = 32'd2;
            src_b    = 32'd3;
            @(negedge clk);
            op_valid = 1'b0;
            check("acc_op_rejected_busy", {31'd0, busy}, 32'd0);
        end
        repeat (5) @(negedge clk);
        check("acc_op_no_finish", 32'(fin_cnt - f0), 32'd0);
`endif
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
